// File: rtl/div3_lookup_arbiter.sv
// div3_lookup_arbiter: round-robin sharing of one external divide-by-3 ROM among NREQ requesters
module div3_lookup_arbiter #(
  parameter int NREQ  = 2,
  parameter int MAXIN = 119
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [6*NREQ-1:0] rsp_quot,
  output logic [2*NREQ-1:0] rsp_rem,
  output logic [NREQ-1:0]   rsp_err,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [6:0]        rom_in,
  input  logic [5:0]        rom_out,
  output logic              busy
);
  localparam int GW = (NREQ > 2) ? 2 : 1;
  localparam logic [6:0] MAXV = 7'(MAXIN);
  typedef enum logic {IDLE, LOOK} state_t;
  state_t r_state;
  logic [GW-1:0] r_last, r_own, w_g;
  logic r_oor, w_found;
  logic [NREQ-1:0] w_elig;
  logic [1:0] w_rem;
  int w_best;
  assign w_elig = req_valid & ~rsp_valid;
  // Rank each eligible requester by its distance after r_last; the nearest one wins.
  always_comb begin
    w_found = 1'b0;
    w_g = '0;
    w_best = NREQ;
    for (int i = 0; i < NREQ; i++)
      if (w_elig[i] && ((i + NREQ - 1 - int'(r_last)) % NREQ) < w_best) begin
        w_best = (i + NREQ - 1 - int'(r_last)) % NREQ;
        w_g = GW'(i);
        w_found = 1'b1;
      end
  end
  assign req_ready = (!rst && r_state == IDLE && w_found) ? (NREQ'(1) << w_g) : '0;
  assign busy = (r_state == LOOK);
  // rom_in - 3*rom_out, only the low two bits survive truncation
  assign w_rem = rom_in[1:0] - rom_out[1:0] - {rom_out[0], 1'b0};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last <= GW'(NREQ - 1);
      r_own <= '0;
      r_oor <= 1'b0;
      rom_in <= '0;
      rsp_valid <= '0;
      rsp_quot <= '0;
      rsp_rem <= '0;
      rsp_err <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (rsp_ready[i]) rsp_valid[i] <= 1'b0;
      if (r_state == IDLE) begin
        if (w_found) begin
          rom_in <= req_data[7*w_g +: 7];
          r_oor <= req_data[7*w_g +: 7] > MAXV;
          r_own <= w_g;
          r_last <= w_g;
          r_state <= LOOK;
        end
      end else begin
        rsp_valid[r_own] <= 1'b1;
        rsp_quot[6*r_own +: 6] <= r_oor ? 6'd0 : rom_out;
        rsp_rem[2*r_own +: 2] <= r_oor ? 2'd0 : w_rem;
        rsp_err[r_own] <= r_oor;
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_div3_lookup_arbiter.sv
// tb_div3_lookup_arbiter: directed stimulus with a per-requester scoreboard checked on response consumption
module tb_div3_lookup_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, busy, garbage;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_err, rsp_ready;
  logic [13:0] req_data;
  logic [11:0] rsp_quot;
  logic [3:0] rsp_rem;
  logic [6:0] rom_in;
  logic [5:0] rom_out;
  int pass_n = 0, tot_n = 0, n1;
  bit found;
  int r;
  logic [8:0] q0[$], q1[$];
  div3_lookup_arbiter #(.NREQ(2), .MAXIN(119)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .rom_in(rom_in), .rom_out(rom_out), .busy(busy)
  );
  assign rom_out = garbage ? 6'h2A : 6'(rom_in / 7'd3);
  function automatic logic [8:0] ref_model(input logic [6:0] x);
    return (x > 7'd119) ? 9'h100 : {1'b0, 6'(x / 7'd3), 2'(x % 7'd3)};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tot_n++;
    if (a !== e) $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    else pass_n++;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (req_ready[0]) q0.push_back(ref_model(req_data[6:0]));
      if (req_ready[1]) q1.push_back(ref_model(req_data[13:7]));
    end
  always @(negedge clk)
    if (!rst) begin
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (q0.size() == 0) begin tot_n++; $display("FAIL sb0: unexpected response %0t", $time); end
        else chk("sb0", {rsp_err[0], rsp_quot[5:0], rsp_rem[1:0]}, q0.pop_front());
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (q1.size() == 0) begin tot_n++; $display("FAIL sb1: unexpected response %0t", $time); end
        else chk("sb1", {rsp_err[1], rsp_quot[11:6], rsp_rem[3:2]}, q1.pop_front());
      end
    end
  task automatic single(input int rq, input logic [6:0] x, input int eq, input int er, input int ee);
    req_data[7*rq +: 7] = x;
    req_valid[rq] = 1'b1;
    @(negedge clk);
    chk("accept", req_ready, 32'(2'b01 << rq));
    step(1);
    req_valid = 2'b00;
    req_data[7*rq +: 7] = ~x;
    @(negedge clk);
    chk("look_busy", busy, 1);
    chk("early_valid", rsp_valid[rq], 0);
    @(negedge clk);
    chk("latency", rsp_valid[rq], 1);
    chk("quot", rsp_quot[6*rq +: 6], eq);
    chk("rem", rsp_rem[2*rq +: 2], er);
    chk("err", rsp_err[rq], ee);
    step(1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; req_valid = 2'b11; req_data = '0; rsp_ready = 2'b00; garbage = 1'b0;
    step(2);
    @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rom_in", rom_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    step(1);
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    single(0, 7'd0, 0, 0, 0);
    single(0, 7'd119, 39, 2, 0);
    single(0, 7'd100, 33, 1, 0);
    garbage = 1'b1;
    single(1, 7'd120, 0, 0, 1);
    single(1, 7'd127, 0, 0, 1);
    garbage = 1'b0;
    req_data = {7'd50, 7'd10};
    req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        chk("rr_grant", req_ready, (c % 4 == 0) ? 2'b01 : 2'b10);
        chk("rr_idle", busy, 0);
      end else begin
        chk("rr_gap", req_ready, 0);
        chk("rr_busy", busy, 1);
      end
    end
    step(1);
    req_valid = 2'b00;
    step(3);
    rsp_ready = 2'b10;
    req_data = {7'd65, 7'd7};
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_fill", req_ready, 2'b01);
    step(1);
    req_valid = 2'b11;
    step(1);
    n1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold", rsp_valid[0], 1);
      chk("bp_stable", {rsp_quot[5:0], rsp_rem[1:0]}, {6'd2, 2'd1});
      chk("bp_no_grant0", req_ready[0], 0);
      if (req_ready[1]) n1++;
    end
    chk("bp_grants1", n1 >= 3, 1);
    step(1);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_same", req_ready[0], 0);
    step(1);
    rsp_ready[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin found = 1'b1; break; end
    end
    chk("bp_regrant", found, 1);
    step(1);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step(4);
    req_data[6:0] = 7'd30;
    req_valid = 2'b01;
    @(negedge clk);
    chk("pre_rst_accept", req_ready[0], 1);
    step(1);
    rst = 1'b1;
    req_valid = 2'b00;
    step(1);
    rst = 1'b0;
    req_data = {7'd5, 7'd4};
    req_valid = 2'b11;
    @(negedge clk);
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_rom_in", rom_in, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant", req_ready, 2'b01);
    step(1);
    req_valid = 2'b00;
    step(4);
    for (int x = 0; x < 128; x++) begin
      r = int'($urandom_range(0, 1));
      req_data[7*r +: 7] = 7'(x);
      req_valid = 2'b00;
      req_valid[r] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (req_ready[r]) begin found = 1'b1; break; end
      end
      chk("sweep_accept", found, 1);
      step(1);
      req_valid = 2'b00;
    end
    step(5);
    chk("sb_drain", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
